// File: rtl/fmap_fetch_pkg.sv
// Shared constants and state encoding for the feature-map fetch stage.
package fmap_fetch_pkg;

  // Height and tile-count field widths from the CNN defines
  localparam int CNN_H_W = 8;
  localparam int CNN_T_W = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fmap_fetch_if.sv
// SRAM read port plus output beat stream of the fetch stage.
interface fmap_fetch_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
);
  // Read port: rd_data is valid the cycle after rd_en. Beat stream: a beat
  // transfers on a cycle with dat_vld & dat_rdy; while dat_vld is high and
  // dat_rdy low, dat/dat_last_h/dat_last hold and dat_vld stays high.
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              dat_vld;
  logic              dat_rdy;
  logic [DATA_W-1:0] dat;
  logic              dat_last_h;
  logic              dat_last;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output dat_vld, dat, dat_last_h, dat_last,
    input  dat_rdy
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  dat_vld, dat, dat_last_h, dat_last,
    output dat_rdy
  );
endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry synchronous FIFO with occupancy count; head entry shown on dout_o.
module fetch_fifo2 #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;

  // The writer never pushes into a full FIFO, so no guard is needed here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fmap_fetch.sv
// Feature-map fetch: walks height, then Win tiles, then Wout tiles, issuing
// SRAM reads and streaming the words out through a 2-entry FIFO.
module fmap_fetch
  import fmap_fetch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int H_W    = CNN_H_W,
  parameter int T_W    = CNN_T_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [H_W-1:0]    cfg_height,
  input  logic [T_W-1:0]    cfg_win_tiles,
  input  logic [T_W-1:0]    cfg_wout_tiles,
  input  logic [ADDR_W-1:0] cfg_base,
  fmap_fetch_if.master      bus,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state_o
);

  localparam int FW = DATA_W + 2;

  state_e            state_q, state_d;
  logic [H_W-1:0]    height_q, h_q;
  logic [T_W-1:0]    win_q, wout_q, wi_q, wo_q;
  logic [ADDR_W-1:0] base_q, ptr_q;
  logic              zero_q, inflight_q, side_last_h_q, side_last_q;
  logic              last_h, last_wi, last_wo, last_rd;
  logic              rd_go, pop, load;
  logic [1:0]        fifo_cnt;
  logic [FW-1:0]     fifo_dout;
  logic [2:0]        occ;

  assign last_h  = (h_q  == height_q - H_W'(1));
  assign last_wi = (wi_q == win_q    - T_W'(1));
  assign last_wo = (wo_q == wout_q   - T_W'(1));
  assign last_rd = last_h & last_wi & last_wo;

  // Occupancy the FIFO will have once this cycle's pop and in-flight word settle
  assign pop   = bus.dat_vld & bus.dat_rdy;
  assign occ   = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
  assign rd_go = (state_q == S_RUN) & ~zero_q & (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (zero_q || (rd_go && last_rd)) state_d = S_DRAIN;
      S_DRAIN: begin
        if (fifo_cnt == 2'd0 && !inflight_q) begin
          done    = 1'b1;
          state_d = start ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new job may start in the very cycle the previous one finishes
  assign load = start & ((state_q == S_IDLE) | done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      height_q      <= '0;
      win_q         <= '0;
      wout_q        <= '0;
      base_q        <= '0;
      zero_q        <= 1'b0;
      ptr_q         <= '0;
      h_q           <= '0;
      wi_q          <= '0;
      wo_q          <= '0;
      inflight_q    <= 1'b0;
      side_last_h_q <= 1'b0;
      side_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= rd_go;
      side_last_h_q <= last_h;
      side_last_q   <= last_rd;
      if (load) begin
        height_q <= cfg_height;
        win_q    <= cfg_win_tiles;
        wout_q   <= cfg_wout_tiles;
        base_q   <= cfg_base;
        zero_q   <= (cfg_height == '0) | (cfg_win_tiles == '0) | (cfg_wout_tiles == '0);
        ptr_q    <= cfg_base;
        h_q      <= '0;
        wi_q     <= '0;
        wo_q     <= '0;
      end else if (rd_go) begin
        if (last_h) begin
          h_q <= '0;
          if (last_wi) begin
            // Each Wout tile re-sweeps the same Win x height region
            wi_q  <= '0;
            wo_q  <= last_wo ? '0 : wo_q + T_W'(1);
            ptr_q <= base_q;
          end else begin
            wi_q  <= wi_q + T_W'(1);
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end else begin
          h_q   <= h_q + H_W'(1);
          ptr_q <= ptr_q + ADDR_W'(1);
        end
      end
    end
  end

  fetch_fifo2 #(.W(FW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   ({side_last_h_q, side_last_q, bus.rd_data}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  assign bus.rd_en      = rd_go;
  assign bus.rd_addr    = ptr_q;
  assign bus.dat_vld    = (fifo_cnt != 2'd0);
  assign bus.dat        = fifo_dout[DATA_W-1:0];
  assign bus.dat_last   = fifo_dout[DATA_W];
  assign bus.dat_last_h = fifo_dout[DATA_W+1];
  assign busy           = (state_q != S_IDLE);
  assign dbg_state_o    = state_q;

endmodule
